// File: rtl/soc_evt_pkg.sv
// Shared event-ID definitions for the peripheral event transmitter and the cluster receiver.
package soc_evt_pkg;

    localparam int EVT_WIDTH_DEF = 8;

    typedef logic [EVT_WIDTH_DEF-1:0] evt_id_t;

    // True when the highest event ID (base + nb_src - 1) can be represented in width bits.
    function automatic bit evt_id_fits(int base, int nb_src, int width);
        longint top;
        top = longint'(base) + longint'(nb_src) - 64'sd1;
        if (width >= 62) return 1'b1;
        return top < (64'sd1 <<< width);
    endfunction

endpackage

// File: rtl/soc_evt_rr_arb.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves past the grant on accept.
module soc_evt_rr_arb #(
    parameter int N     = 32,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             accept_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             valid_o,
    output logic [IDX_W-1:0] ptr_o
);

    logic [IDX_W-1:0] ptr;
    int               j;

    // The first requester found at or after ptr, wrapping at N, wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        j           = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!valid_o && req_i[IDX_W'(j)]) begin
                valid_o                = 1'b1;
                grant_idx_o            = IDX_W'(j);
                grant_o[IDX_W'(j)]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (accept_i && valid_o) begin
            ptr <= (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + IDX_W'(1);
        end
    end

    assign ptr_o = ptr;

endmodule

// File: rtl/soc_periph_evt_tx.sv
// Collects single-cycle peripheral event pulses and forwards them, one ID per cycle, to the cluster event FIFO.
// Build option SOC_PERIPH_EVT_TX_MASK_EN adds the src_mask_i per-source enable port.
module soc_periph_evt_tx
    import soc_evt_pkg::*;
#(
    parameter int NB_SRC     = 32,
    parameter int EVNT_WIDTH = EVT_WIDTH_DEF,
    parameter int ID_BASE    = 0,
    parameter int CNT_W      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NB_SRC-1:0]     src_evt_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [EVNT_WIDTH-1:0] evt_data_o,
    output logic                  overflow_o,
    output logic                  busy_o
`ifdef SOC_PERIPH_EVT_TX_MASK_EN
    ,
    input  logic [NB_SRC-1:0]     src_mask_i
`endif
);

    localparam int               IDX_W   = $clog2(NB_SRC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (NB_SRC < 2 || NB_SRC > 256) begin : g_nb_src_chk
        $error("soc_periph_evt_tx: NB_SRC must be in 2..256");
    end
    if (!evt_id_fits(ID_BASE, NB_SRC, EVNT_WIDTH)) begin : g_width_chk
        $error("soc_periph_evt_tx: EVNT_WIDTH too narrow for ID_BASE+NB_SRC-1");
    end

    logic [NB_SRC-1:0] mask;
    logic [NB_SRC-1:0] inc;
    logic [NB_SRC-1:0] dec;
    logic [NB_SRC-1:0] req;
    logic [NB_SRC-1:0] nz;
    logic [NB_SRC-1:0] drop;
    logic [NB_SRC-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic              grant_valid;
    logic              loadable;
    logic              accept;

`ifdef SOC_PERIPH_EVT_TX_MASK_EN
    assign mask = src_mask_i;
`else
    assign mask = '1;
`endif

    // Handshake: an ID moves to the FIFO at a rising edge where evt_valid_o and evt_ready_i
    // are both 1; once valid is raised, ID and valid stay put until that edge (or a reset).
    assign loadable = ~evt_valid_o | evt_ready_i;
    assign accept   = loadable & grant_valid;

    for (genvar k = 0; k < NB_SRC; k++) begin : g_src
        logic [CNT_W-1:0] cnt;

        assign inc[k]  = src_evt_i[k] & mask[k];
        assign dec[k]  = accept & grant[k];
        assign nz[k]   = (cnt != '0);
        assign req[k]  = mask[k] & nz[k];
        assign drop[k] = inc[k] & ~dec[k] & (cnt == CNT_MAX);

        // Simultaneous increment and decrement cancel; a pulse into a full counter is lost.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt <= '0;
            end else if (inc[k] && !dec[k] && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end else if (dec[k] && !inc[k]) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    soc_evt_rr_arb #(
        .N     (NB_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .valid_o     (grant_valid),
        .ptr_o       (rr_ptr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_valid_o <= 1'b0;
            evt_data_o  <= '0;
            overflow_o  <= 1'b0;
        end else begin
            overflow_o <= |drop;
            if (loadable) begin
                evt_valid_o <= grant_valid;
                if (grant_valid) begin
                    evt_data_o <= EVNT_WIDTH'(ID_BASE) + EVNT_WIDTH'(grant_idx);
                end
            end
        end
    end

    assign busy_o = (|nz) | evt_valid_o;

endmodule

// File: tb/tb_soc_periph_evt_tx.sv
// Directed bench for soc_periph_evt_tx (default parameters); mask steps run when SOC_PERIPH_EVT_TX_MASK_EN is defined.
module tb_soc_periph_evt_tx;

  localparam int NB_SRC     = 32;
  localparam int EVNT_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NB_SRC-1:0]     src_evt = '0;
  logic                  evt_ready = 1'b1;
  logic                  evt_valid;
  logic [EVNT_WIDTH-1:0] evt_data;
  logic                  overflow;
  logic                  busy;
`ifdef SOC_PERIPH_EVT_TX_MASK_EN
  logic [NB_SRC-1:0]     src_mask = '1;
`endif

  int total = 0;
  int bad   = 0;
  int ovf_cnt = 0;
  int qb;
  int ob;
  logic [EVNT_WIDTH-1:0] got_q[$];

  always #5 clk = ~clk;

  soc_periph_evt_tx #(
    .NB_SRC     (NB_SRC),
    .EVNT_WIDTH (EVNT_WIDTH),
    .ID_BASE    (0),
    .CNT_W      (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_evt_i   (src_evt),
    .evt_valid_o (evt_valid),
    .evt_ready_i (evt_ready),
    .evt_data_o  (evt_data),
    .overflow_o  (overflow),
    .busy_o      (busy)
`ifdef SOC_PERIPH_EVT_TX_MASK_EN
    ,
    .src_mask_i  (src_mask)
`endif
  );

  // Transfers and overflow pulses as the next rising edge will see them.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) got_q.push_back(evt_data);
    if (!rst && overflow) ovf_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input int idx);
    if (idx < got_q.size()) return 32'(got_q[idx]);
    return 32'hxxxx_xxxx;
  endfunction

  initial begin
    // Reset state
    step();
    step();
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_data", 32'(evt_data), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // Single pulse on source 5, minimum latency
    qb = got_q.size();
    src_evt = 32'h1 << 5;
    step();
    src_evt = '0;
    check("s5_t1_valid", 32'(evt_valid), 0);
    check("s5_t1_busy", 32'(busy), 1);
    step();
    check("s5_t2_valid", 32'(evt_valid), 1);
    check("s5_t2_data", 32'(evt_data), 5);
    step();
    check("s5_t3_valid", 32'(evt_valid), 0);
    check("s5_t3_busy", 32'(busy), 0);
    check("s5_count", got_q.size() - qb, 1);
    check("s5_id", q_at(qb), 5);

    // Three sources in one cycle after reset: 0, 3, 31 back to back
    rst = 1'b1;
    step();
    rst = 1'b0;
    qb = got_q.size();
    src_evt = (32'h1 << 0) | (32'h1 << 3) | (32'h1 << 31);
    step();
    src_evt = '0;
    check("m3_t1_valid", 32'(evt_valid), 0);
    step();
    check("m3_t2_data", 32'(evt_data), 0);
    step();
    check("m3_t3_data", 32'(evt_data), 3);
    check("m3_t3_valid", 32'(evt_valid), 1);
    step();
    check("m3_t4_data", 32'(evt_data), 31);
    step();
    check("m3_t5_valid", 32'(evt_valid), 0);
    check("m3_count", got_q.size() - qb, 3);
    check("m3_id0", q_at(qb), 0);
    check("m3_id1", q_at(qb + 1), 3);
    check("m3_id2", q_at(qb + 2), 31);

    // Backpressure: source 7 held stable for 20 cycles
    evt_ready = 1'b0;
    qb = got_q.size();
    src_evt = 32'h1 << 7;
    step();
    src_evt = '0;
    step();
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", 32'(evt_valid), 1);
      check("hold_data", 32'(evt_data), 7);
      step();
    end
    check("hold_end_valid", 32'(evt_valid), 1);
    evt_ready = 1'b1;
    step();
    check("hold_rel_valid", 32'(evt_valid), 0);
    step();
    step();
    check("hold_count", got_q.size() - qb, 1);
    check("hold_id", q_at(qb), 7);

    // Saturation: output register busy with 9, four pulses on source 2
    evt_ready = 1'b0;
    qb = got_q.size();
    ob = ovf_cnt;
    src_evt = 32'h1 << 9;
    step();
    src_evt = '0;
    step();
    check("sat_hold_data", 32'(evt_data), 9);
    for (int i = 0; i < 4; i++) begin
      src_evt = 32'h1 << 2;
      step();
      check("sat_ovf_step", 32'(overflow), (i == 3) ? 1 : 0);
    end
    src_evt = '0;
    step();
    check("sat_ovf_after", 32'(overflow), 0);
    check("sat_ovf_count", ovf_cnt - ob, 1);
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("sat_count", got_q.size() - qb, 4);
    check("sat_id0", q_at(qb), 9);
    check("sat_id1", q_at(qb + 1), 2);
    check("sat_id2", q_at(qb + 2), 2);
    check("sat_id3", q_at(qb + 3), 2);
    check("sat_busy", 32'(busy), 0);

    // Pulse on source 1 in the same cycle it is granted with cnt=1
    qb = got_q.size();
    src_evt = 32'h1 << 1;
    step();
    check("sim_t1_valid", 32'(evt_valid), 0);
    step();
    src_evt = '0;
    check("sim_t2_valid", 32'(evt_valid), 1);
    check("sim_t2_data", 32'(evt_data), 1);
    step();
    check("sim_t3_valid", 32'(evt_valid), 1);
    check("sim_t3_data", 32'(evt_data), 1);
    step();
    check("sim_t4_valid", 32'(evt_valid), 0);
    check("sim_t4_busy", 32'(busy), 0);
    check("sim_count", got_q.size() - qb, 2);

    // Reset while a transfer is stalled discards it and the pending counters
    evt_ready = 1'b0;
    src_evt = (32'h1 << 6) | (32'h1 << 8);
    step();
    src_evt = '0;
    step();
    check("rstx_valid_pre", 32'(evt_valid), 1);
    check("rstx_data_pre", 32'(evt_data), 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstx_valid", 32'(evt_valid), 0);
    check("rstx_data", 32'(evt_data), 0);
    check("rstx_busy", 32'(busy), 0);
    qb = got_q.size();
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("rstx_no_xfer", got_q.size() - qb, 0);
    check("rstx_valid_after", 32'(evt_valid), 0);

    // Pointer restarts at 0 after reset: 1 beats 4
    src_evt = (32'h1 << 1) | (32'h1 << 4);
    step();
    src_evt = '0;
    step();
    check("rr_first", 32'(evt_data), 1);
    step();
    check("rr_second", 32'(evt_data), 4);
    step();
    check("rr_done", 32'(evt_valid), 0);
    check("rr_count", got_q.size() - qb, 2);

`ifdef SOC_PERIPH_EVT_TX_MASK_EN
    // Masked source 4 is ignored while source 10 still flows
    qb = got_q.size();
    src_mask = ~(32'h1 << 4);
    src_evt = (32'h1 << 4) | (32'h1 << 10);
    step();
    src_evt = '0;
    step();
    check("mask_data", 32'(evt_data), 10);
    for (int i = 0; i < 4; i++) step();
    check("mask_count", got_q.size() - qb, 1);
    check("mask_id", q_at(qb), 10);
    check("mask_busy", 32'(busy), 0);
    src_mask = '1;
    step();
    check("mask_restore_count", got_q.size() - qb, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case a step sequence stalls
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/soc_periph_evt_tx.md
SOC_PERIPH_EVT_TX -- requirements
Module: soc_periph_evt_tx

Interface
REQ-001 SHALL have parameter NB_SRC, 32, number of peripheral event sources (2..256).
REQ-002 SHALL have parameter EVNT_WIDTH, 8, width of the transmitted event ID.
REQ-003 SHALL have parameter ID_BASE, 0, event ID sent for source 0; source k sends ID_BASE+k.
REQ-004 SHALL have parameter CNT_W, 2, width of each per-source pending counter.
REQ-005 SHALL have port clk_i  input  1  clock; one clock, all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port src_evt_i  input  NB_SRC  single-cycle event pulses, one bit per source.
REQ-008 SHALL have port evt_valid_o  output  1  event ID available to the cluster event FIFO.
REQ-009 SHALL have port evt_ready_i  input  1  cluster FIFO not full (the cluster's fifo_fulln).
REQ-010 SHALL have port evt_data_o  output  EVNT_WIDTH  event ID.
REQ-011 SHALL have port overflow_o  output  1  one-cycle pulse: an event pulse was dropped.
REQ-012 SHALL have port busy_o  output  1  any counter nonzero or evt_valid_o high.

Function
REQ-013 Each source SHALL have a saturating pending counter of CNT_W bits.
REQ-014 A pulse on src_evt_i[k] in cycle t SHALL be visible in cnt[k] in cycle t+1.
REQ-015 The output register SHALL be loadable in cycle t when evt_valid_o=0, or when evt_valid_o=1 and evt_ready_i=1.
REQ-016 When loadable and any cnt!=0, the round-robin arbiter SHALL grant one source; at the edge, evt_data_o <= ID_BASE+grant, evt_valid_o <= 1, cnt[grant] decrements.
REQ-017 When loadable and all cnt=0, evt_valid_o SHALL go to 0 at the edge.
REQ-018 Minimum latency: a pulse in cycle t with an idle block SHALL give evt_valid_o=1 in cycle t+2.
REQ-019 While evt_valid_o=1 and evt_ready_i=0, evt_data_o and evt_valid_o SHALL be held stable.
REQ-020 Back-to-back transfers SHALL sustain one event per cycle while evt_ready_i=1 and events are pending.
REQ-021 Round-robin: after a grant to source g, the search SHALL start at g+1 modulo NB_SRC; after reset, the search starts at source 0.
REQ-022 Increment and decrement of the same counter in the same cycle SHALL leave it unchanged.
REQ-023 A pulse to a saturated counter (2^CNT_W-1) that is not decremented in the same cycle SHALL be dropped; overflow_o SHALL pulse in cycle t+1.
REQ-024 EVNT_WIDTH SHALL be wide enough for ID_BASE+NB_SRC-1, checked by elaboration-time assertion; the sum SHALL be truncated to EVNT_WIDTH.

Reset
REQ-025 On rst_i=1 at a clock edge: all counters 0, evt_valid_o=0, evt_data_o=0, overflow_o=0, busy_o=0, RR pointer=0; pulses in reset cycles are discarded.
REQ-026 A reset asserted while evt_valid_o=1 and evt_ready_i=0 SHALL discard the pending transfer without a handshake.

Configuration
REQ-027 With SOC_PERIPH_EVT_TX_MASK_EN defined, a port src_mask_i (input, NB_SRC) SHALL exist; a source with mask bit 0 SHALL neither count pulses nor be granted, and its counter SHALL hold its value.
REQ-028 Without SOC_PERIPH_EVT_TX_MASK_EN, the src_mask_i port SHALL not exist and all sources SHALL be enabled.

Structure
REQ-029 Package soc_evt_pkg SHALL hold the default EVNT_WIDTH constant and the evt_id_t typedef, shared with the cluster-side receiver.
REQ-030 Arbitration SHALL be the sub-module soc_evt_rr_arb (request vector in; one-hot grant, grant index and valid out; pointer update on an accept strobe).

Verification
REQ-031 Single pulse on src 5 in cycle 10, ready=1 -> evt_valid_o=1 with evt_data_o=5 in cycle 12 only; busy_o returns to 0 in cycle 13.
REQ-032 Pulses on src 0, 3 and 31 in the same cycle, ready=1 -> IDs 0, 3, 31 on three consecutive cycles.
REQ-033 Ready=0 for 20 cycles with src 7 pending -> ID 7 held stable for all 20 cycles; exactly one transfer once ready=1.
REQ-034 CNT_W=2, ready=0, 4 pulses on src 2 -> overflow_o pulses once; after ready=1, exactly 3 transfers of ID 2.
REQ-035 Simultaneous pulse and grant on src 1 with cnt=1 and ready=1 -> cnt stays 1 and a second ID 1 follows.
REQ-036 rst_i asserted while valid=1 and ready=0 -> next cycle valid=0 and counters 0; with the mask feature built in and mask[4]=0, pulses on src 4 produce no transfer.
